// File: rtl/aom_trig_overload_mc.sv
// -----------------------------------------------------------------------------
// aom_trig_overload_mc
//
// Per-channel AOM trigger overload monitor. For every channel it detects two
// kinds of overload while the laser is emitting:
//   * continuous: the channel stays triggered (voltage below threshold) for at
//     least aom_continuous_trig_thre_i consecutive cycles;
//   * integral:   within a WIN_LEN-cycle window that opens on the first active
//     cycle, the channel is triggered on at least aom_integral_trig_thre_i
//     cycles.
// Detected errors are sticky per channel until cleared, and the channel/type
// of the first fault after an all-clear state is latched for diagnosis.
//
// Ports
//   clk_i                      system clock, rising edge
//   rst_n_i                    asynchronous active-low reset
//   laser_control_i            0 = laser emitting
//   laser_out_switch_i         1 = external control selected
//   acc_job_control_i          job running
//   aom_trig_protect_i         protection enable
//   aom_en_i[CH_NUM]           per-channel voltage-update strobe
//   aom_voltage_i              packed voltages, channel c at [c*VOL_W +: VOL_W]
//   aom_trig_vol_thre_i        trigger voltage threshold (all channels)
//   aom_continuous_trig_thre_i continuous-count threshold, 0 = check disabled
//   aom_integral_trig_thre_i   integral-count threshold, 0 = check disabled
//   ch_mask_i[CH_NUM]          1 = channel excluded from monitoring
//   err_clr_i                  one-cycle clear of the sticky errors
//   aom_continuous_trig_err_o  sticky continuous errors, one bit per channel
//   aom_integral_trig_err_o    sticky integral errors, one bit per channel
//   err_any_o                  OR of all sticky error bits
//   first_err_ch_o             channel of the first fault
//   first_err_type_o           type of the first fault (0 cont, 1 integral)
// -----------------------------------------------------------------------------
module aom_trig_overload_mc #(
  parameter int          CH_NUM  = 4,
  parameter int          VOL_W   = 12,
  parameter int          CNT_W   = 32,
  parameter int unsigned WIN_LEN = 100_000_000
) (
  input  logic                                         clk_i,
  input  logic                                         rst_n_i,
  input  logic                                         laser_control_i,
  input  logic                                         laser_out_switch_i,
  input  logic                                         acc_job_control_i,
  input  logic                                         aom_trig_protect_i,
  input  logic [CH_NUM-1:0]                            aom_en_i,
  input  logic [CH_NUM*VOL_W-1:0]                      aom_voltage_i,
  input  logic [VOL_W-1:0]                             aom_trig_vol_thre_i,
  input  logic [CNT_W-1:0]                             aom_continuous_trig_thre_i,
  input  logic [CNT_W-1:0]                             aom_integral_trig_thre_i,
  input  logic [CH_NUM-1:0]                            ch_mask_i,
  input  logic                                         err_clr_i,
  output logic [CH_NUM-1:0]                            aom_continuous_trig_err_o,
  output logic [CH_NUM-1:0]                            aom_integral_trig_err_o,
  output logic                                         err_any_o,
  output logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] first_err_ch_o,
  output logic                                         first_err_type_o
);

  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  // Value of win_cnt on the last cycle of a window.
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_LEN - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_WINDOW = 1'b1
  } int_state_t;

  // ---------------------------------------------------------------------------
  // Global qualifiers
  // ---------------------------------------------------------------------------
  logic arm;
  logic emit;

  assign arm  = aom_trig_protect_i & acc_job_control_i;
  assign emit = ~laser_control_i & laser_out_switch_i;

  // ---------------------------------------------------------------------------
  // Per-channel state
  // ---------------------------------------------------------------------------
  logic [CH_NUM-1:0] trig_vld;
  logic [CH_NUM-1:0] act;
  logic [CNT_W-1:0]  cont_cnt  [CH_NUM];
  logic [CNT_W-1:0]  win_cnt   [CH_NUM];
  logic [CNT_W-1:0]  int_cnt   [CH_NUM];
  int_state_t        int_state [CH_NUM];
  logic [CH_NUM-1:0] cont_raw;
  logic [CH_NUM-1:0] int_raw;

  // trig_vld holds its last comparison until the channel strobes a new voltage.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values no matter how the always_ff blocks are ordered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      trig_vld <= '0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (aom_en_i[c]) begin
          trig_vld[c] <= (aom_voltage_i[c*VOL_W +: VOL_W] < aom_trig_vol_thre_i);
        end
      end
    end
  end

  assign act = {CH_NUM{arm}} & trig_vld & ~ch_mask_i;

  // ---------------------------------------------------------------------------
  // Continuous counter: consecutive active cycles, saturating.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the per-channel counter arrays are ordinary flops rather than a
      // RAM, so they are reset element by element like any other register.
      for (int c = 0; c < CH_NUM; c++) begin
        cont_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (!act[c]) begin
          cont_cnt[c] <= '0;
        end else if (cont_cnt[c] != CNT_MAX) begin
          cont_cnt[c] <= cont_cnt[c] + CNT_ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Integral window FSM, one per channel.
  // A window opens on the first active cycle and then runs for exactly WIN_LEN
  // cycles, counting every cycle in which the channel is triggered. On the last
  // window cycle the count is still updated, so the first IDLE cycle exposes
  // the final window total to the raw-flag stage before IDLE clears it.
  // Dropping arm or masking the channel abandons the window at once.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < CH_NUM; c++) begin
        int_state[c] <= ST_IDLE;
        win_cnt[c]   <= '0;
        int_cnt[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        case (int_state[c])
          ST_IDLE: begin
            win_cnt[c] <= '0;
            int_cnt[c] <= '0;
            if (act[c]) begin
              int_state[c] <= ST_WINDOW;
            end
          end

          ST_WINDOW: begin
            if (!arm || ch_mask_i[c]) begin
              int_state[c] <= ST_IDLE;
              win_cnt[c]   <= '0;
              int_cnt[c]   <= '0;
            end else begin
              win_cnt[c] <= win_cnt[c] + CNT_ONE;
              if (trig_vld[c] && (int_cnt[c] != CNT_MAX)) begin
                int_cnt[c] <= int_cnt[c] + CNT_ONE;
              end
              if (win_cnt[c] == WIN_LAST) begin
                int_state[c] <= ST_IDLE;
              end
            end
          end

          default: begin
            int_state[c] <= ST_IDLE;
            win_cnt[c]   <= '0;
            int_cnt[c]   <= '0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Raw error flags. Thresholds are sampled live, so a new threshold acts on
  // the next comparison without disturbing an open window.
  // ---------------------------------------------------------------------------
  logic cont_chk_en;
  logic int_chk_en;

  assign cont_chk_en = (aom_continuous_trig_thre_i != '0);
  assign int_chk_en  = (aom_integral_trig_thre_i != '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cont_raw <= '0;
      int_raw  <= '0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        cont_raw[c] <= emit && cont_chk_en && (cont_cnt[c] >= aom_continuous_trig_thre_i);
        int_raw[c]  <= emit && int_chk_en  && (int_cnt[c]  >= aom_integral_trig_thre_i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky errors: a raw flag always sets its bit; a clear only removes bits
  // whose raw flag is low in the same cycle.
  // ---------------------------------------------------------------------------
  logic [CH_NUM-1:0] cont_err_nxt;
  logic [CH_NUM-1:0] int_err_nxt;
  logic              err_any_nxt;

  assign cont_err_nxt = cont_raw | (aom_continuous_trig_err_o & ~{CH_NUM{err_clr_i}});
  assign int_err_nxt  = int_raw  | (aom_integral_trig_err_o   & ~{CH_NUM{err_clr_i}});
  assign err_any_nxt  = |{cont_err_nxt, int_err_nxt};

  // Lowest-index setting channel; continuous beats integral on that channel.
  logic [CH_W-1:0] first_ch_sel;
  logic            first_type_sel;

  // NOTE: every variable gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    first_ch_sel   = '0;
    first_type_sel = 1'b0;
    for (int c = CH_NUM - 1; c >= 0; c--) begin
      if (cont_raw[c] || int_raw[c]) begin
        first_ch_sel   = CH_W'(c);
        first_type_sel = ~cont_raw[c];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      aom_continuous_trig_err_o <= '0;
      aom_integral_trig_err_o   <= '0;
      err_any_o                 <= 1'b0;
      first_err_ch_o            <= '0;
      first_err_type_o          <= 1'b0;
    end else begin
      aom_continuous_trig_err_o <= cont_err_nxt;
      aom_integral_trig_err_o   <= int_err_nxt;
      err_any_o                 <= err_any_nxt;
      if (!err_any_nxt) begin
        first_err_ch_o   <= '0;
        first_err_type_o <= 1'b0;
      end else if (!err_any_o) begin
        // All-clear to fault transition: the setting raw flags name the culprit.
        first_err_ch_o   <= first_ch_sel;
        first_err_type_o <= first_type_sel;
      end
    end
  end

endmodule

// File: tb/tb_aom_trig_overload_mc.sv
// -----------------------------------------------------------------------------
// tb_aom_trig_overload_mc
//
// Directed bench for aom_trig_overload_mc with CH_NUM=4, VOL_W=12, CNT_W=8,
// WIN_LEN=16. Inputs are driven 1 ns after the rising edge and outputs are
// sampled at the same point. "Cycle 0" is the first cycle in which trig_vld
// reflects the voltage applied right after reset release.
// -----------------------------------------------------------------------------
module tb_aom_trig_overload_mc;

  localparam int          CH_NUM  = 4;
  localparam int          VOL_W   = 12;
  localparam int          CNT_W   = 8;
  localparam int unsigned WIN_LEN = 16;

  localparam logic [11:0] VLO  = 12'd100;
  localparam logic [11:0] VHI  = 12'd4000;
  localparam logic [11:0] VTHR = 12'd2048;

  localparam logic [31:0] ST_IDLE   = 32'd0;
  localparam logic [31:0] ST_WINDOW = 32'd1;

  logic                      clk_i = 1'b0;
  logic                      rst_n_i;
  logic                      laser_control_i;
  logic                      laser_out_switch_i;
  logic                      acc_job_control_i;
  logic                      aom_trig_protect_i;
  logic [CH_NUM-1:0]         aom_en_i;
  logic [CH_NUM*VOL_W-1:0]   aom_voltage_i;
  logic [VOL_W-1:0]          aom_trig_vol_thre_i;
  logic [CNT_W-1:0]          aom_continuous_trig_thre_i;
  logic [CNT_W-1:0]          aom_integral_trig_thre_i;
  logic [CH_NUM-1:0]         ch_mask_i;
  logic                      err_clr_i;
  logic [CH_NUM-1:0]         aom_continuous_trig_err_o;
  logic [CH_NUM-1:0]         aom_integral_trig_err_o;
  logic                      err_any_o;
  logic [1:0]                first_err_ch_o;
  logic                      first_err_type_o;

  aom_trig_overload_mc #(
    .CH_NUM  (CH_NUM),
    .VOL_W   (VOL_W),
    .CNT_W   (CNT_W),
    .WIN_LEN (WIN_LEN)
  ) dut (
    .clk_i                      (clk_i),
    .rst_n_i                    (rst_n_i),
    .laser_control_i            (laser_control_i),
    .laser_out_switch_i         (laser_out_switch_i),
    .acc_job_control_i          (acc_job_control_i),
    .aom_trig_protect_i         (aom_trig_protect_i),
    .aom_en_i                   (aom_en_i),
    .aom_voltage_i              (aom_voltage_i),
    .aom_trig_vol_thre_i        (aom_trig_vol_thre_i),
    .aom_continuous_trig_thre_i (aom_continuous_trig_thre_i),
    .aom_integral_trig_thre_i   (aom_integral_trig_thre_i),
    .ch_mask_i                  (ch_mask_i),
    .err_clr_i                  (err_clr_i),
    .aom_continuous_trig_err_o  (aom_continuous_trig_err_o),
    .aom_integral_trig_err_o    (aom_integral_trig_err_o),
    .err_any_o                  (err_any_o),
    .first_err_ch_o             (first_err_ch_o),
    .first_err_type_o           (first_err_type_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic set_vol(input int ch, input logic [11:0] v);
    aom_voltage_i[ch*VOL_W +: VOL_W] = v;
  endtask

  // Armed, emitting, all channels strobing a high (non-triggering) voltage.
  task automatic idle_inputs();
    laser_control_i            = 1'b0;
    laser_out_switch_i         = 1'b1;
    acc_job_control_i          = 1'b1;
    aom_trig_protect_i         = 1'b1;
    aom_en_i                   = '1;
    for (int c = 0; c < CH_NUM; c++) set_vol(c, VHI);
    aom_trig_vol_thre_i        = VTHR;
    aom_continuous_trig_thre_i = '0;
    aom_integral_trig_thre_i   = '0;
    ch_mask_i                  = '0;
    err_clr_i                  = 1'b0;
  endtask

  // Leaves the bench 1 ns after the edge following release; the next edge
  // loads trig_vld, so one step() afterwards lands in cycle 0.
  task automatic do_reset();
    rst_n_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  // ch1 toggles its trigger every cycle; 8 of the 16 window cycles trigger.
  task automatic run_toggle(input logic [7:0] thre, input logic exp_err);
    idle_inputs();
    aom_integral_trig_thre_i = thre;
    do_reset();
    for (int j = 0; j <= 19; j++) begin
      set_vol(1, (j % 2 == 0) ? VLO : VHI);
      step();
      if (j == 17) begin
        check("tog_state_c17", 32'(dut.int_state[1]), ST_IDLE);
        check("tog_intcnt_c17", 32'(dut.int_cnt[1]), 32'd8);
      end
      if (j == 18) check("tog_interr_c18", 32'(aom_integral_trig_err_o), 32'd0);
      if (j == 19) begin
        check("tog_interr_c19", 32'(aom_integral_trig_err_o), 32'({2'b00, exp_err, 1'b0}));
        check("tog_restart_state", 32'(dut.int_state[1]), ST_WINDOW);
        check("tog_restart_wincnt", 32'(dut.win_cnt[1]), 32'd0);
        check("tog_conterr", 32'(aom_continuous_trig_err_o), 32'd0);
        if (exp_err) begin
          check("tog_first_ch", 32'(first_err_ch_o), 32'd1);
          check("tog_first_type", 32'(first_err_type_o), 32'd1);
        end
      end
    end
    if (!exp_err) begin
      for (int j = 20; j <= 40; j++) begin
        set_vol(1, (j % 2 == 0) ? VLO : VHI);
        step();
      end
      check("tog9_interr_c40", 32'(aom_integral_trig_err_o), 32'd0);
    end
  endtask

  typedef struct {
    string       name;
    logic [11:0] vol;
    logic [7:0]  ct;
    logic        mask;
    logic        emit;
    logic        arm;
    logic [3:0]  exp_cont;
    logic        exp_any;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [11:0] v, input logic [7:0] ct,
                              input logic m, input logic e, input logic a,
                              input logic [3:0] ec, input logic ea);
    vec_t r;
    r.name = n; r.vol = v; r.ct = ct; r.mask = m; r.emit = e; r.arm = a;
    r.exp_cont = ec; r.exp_any = ea;
    return r;
  endfunction

  vec_t vecs [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // ch0 static stimulus, sampled at cycle 9; continuous error appears at
    // cycle thre+2, so thre 7 just reaches it and thre 8 just misses.
    vecs[0] = mk("basic",       VLO,     8'd5, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b1);
    vecs[1] = mk("vol_eq_thre", VTHR,    8'd5, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
    vecs[2] = mk("vol_below",   12'd2047, 8'd5, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b1);
    vecs[3] = mk("masked",      VLO,     8'd5, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0);
    vecs[4] = mk("thre_zero",   VLO,     8'd0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
    vecs[5] = mk("no_emit",     VLO,     8'd5, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
    vecs[6] = mk("no_arm",      VLO,     8'd5, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    vecs[7] = mk("thre7_edge",  VLO,     8'd7, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b1);
    vecs[8] = mk("thre8_edge",  VLO,     8'd8, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);

    // Reset state
    rst_n_i = 1'b1;
    idle_inputs();
    #2 rst_n_i = 1'b0;
    #20;
    check("rst_conterr", 32'(aom_continuous_trig_err_o), 32'd0);
    check("rst_interr", 32'(aom_integral_trig_err_o), 32'd0);
    check("rst_any", 32'(err_any_o), 32'd0);
    check("rst_first_ch", 32'(first_err_ch_o), 32'd0);
    check("rst_first_type", 32'(first_err_type_o), 32'd0);
    @(posedge clk_i);
    #1;

    // Table-driven continuous-check vectors on ch0
    for (int i = 0; i < 9; i++) begin
      idle_inputs();
      set_vol(0, vecs[i].vol);
      aom_continuous_trig_thre_i = vecs[i].ct;
      ch_mask_i[0]               = vecs[i].mask;
      laser_control_i            = ~vecs[i].emit;
      aom_trig_protect_i         = vecs[i].arm;
      do_reset();
      step();
      steps(9);
      check({vecs[i].name, "_cont"}, 32'(aom_continuous_trig_err_o), 32'(vecs[i].exp_cont));
      check({vecs[i].name, "_any"}, 32'(err_any_o), 32'(vecs[i].exp_any));
    end

    // Continuous threshold 5: error rises exactly at cycle 7
    idle_inputs();
    set_vol(0, VLO);
    aom_continuous_trig_thre_i = 8'd5;
    do_reset();
    step();
    steps(6);
    check("cont5_c6", 32'(aom_continuous_trig_err_o), 32'd0);
    step();
    check("cont5_c7", 32'(aom_continuous_trig_err_o), 32'b0001);
    check("cont5_interr", 32'(aom_integral_trig_err_o), 32'd0);
    check("cont5_first_ch", 32'(first_err_ch_o), 32'd0);
    check("cont5_first_type", 32'(first_err_type_o), 32'd0);

    // Integral window, 1-of-2 triggering
    run_toggle(8'd8, 1'b1);
    run_toggle(8'd9, 1'b0);

    // ch2 and ch3 fault together; clear behaviour
    idle_inputs();
    set_vol(2, VLO);
    set_vol(3, VLO);
    aom_continuous_trig_thre_i = 8'd3;
    do_reset();
    step();
    steps(4);
    check("dual_c4", 32'(aom_continuous_trig_err_o), 32'd0);
    step();
    check("dual_c5", 32'(aom_continuous_trig_err_o), 32'b1100);
    check("dual_first_ch", 32'(first_err_ch_o), 32'd2);
    check("dual_first_type", 32'(first_err_type_o), 32'd0);
    check("dual_any", 32'(err_any_o), 32'd1);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    check("clr_raw_high", 32'(aom_continuous_trig_err_o), 32'b1100);
    set_vol(2, VHI);
    set_vol(3, VHI);
    steps(4);
    check("sticky_after_raw_drop", 32'(aom_continuous_trig_err_o), 32'b1100);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    check("clr_conterr", 32'(aom_continuous_trig_err_o), 32'd0);
    check("clr_any", 32'(err_any_o), 32'd0);
    check("clr_first_ch", 32'(first_err_ch_o), 32'd0);
    check("clr_first_type", 32'(first_err_type_o), 32'd0);

    // Protection drop mid-window
    idle_inputs();
    set_vol(0, VLO);
    do_reset();
    step();
    steps(5);
    check("prot_in_window", 32'(dut.int_state[0]), ST_WINDOW);
    check("prot_wincnt_pre", 32'(dut.win_cnt[0]), 32'd4);
    aom_trig_protect_i = 1'b0;
    step();
    check("prot_state", 32'(dut.int_state[0]), ST_IDLE);
    check("prot_wincnt", 32'(dut.win_cnt[0]), 32'd0);
    check("prot_intcnt", 32'(dut.int_cnt[0]), 32'd0);
    check("prot_contcnt", 32'(dut.cont_cnt[0]), 32'd0);

    // Reset mid-window with both errors set
    idle_inputs();
    set_vol(0, VLO);
    aom_continuous_trig_thre_i = 8'd3;
    aom_integral_trig_thre_i   = 8'd4;
    do_reset();
    step();
    steps(8);
    check("prerst_cont", 32'(aom_continuous_trig_err_o), 32'b0001);
    check("prerst_int", 32'(aom_integral_trig_err_o), 32'b0001);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("asyncrst_cont", 32'(aom_continuous_trig_err_o), 32'd0);
    check("asyncrst_int", 32'(aom_integral_trig_err_o), 32'd0);
    check("asyncrst_any", 32'(err_any_o), 32'd0);
    check("asyncrst_state", 32'(dut.int_state[0]), ST_IDLE);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    step();
    steps(4);
    check("postrst_cont_c4", 32'(aom_continuous_trig_err_o), 32'd0);
    step();
    check("postrst_cont_c5", 32'(aom_continuous_trig_err_o), 32'b0001);
    step();
    check("postrst_int_c6", 32'(aom_integral_trig_err_o), 32'd0);
    step();
    check("postrst_int_c7", 32'(aom_integral_trig_err_o), 32'b0001);

    // Continuous counter saturation at 255 (CNT_W = 8)
    idle_inputs();
    set_vol(0, VLO);
    aom_continuous_trig_thre_i = 8'd255;
    do_reset();
    step();
    steps(299);
    check("sat_cnt", 32'(dut.cont_cnt[0]), 32'd255);
    check("sat_err", 32'(aom_continuous_trig_err_o), 32'b0001);
    step();
    check("sat_nowrap", 32'(dut.cont_cnt[0]), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
